// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
//   Drives a 4-digit multiplexed seven-segment display from a small
//   register-write interface. Digits are lit one at a time, with an optional
//   all-dark gap between digits to suppress ghosting. DATA and CTRL (dp, blank)
//   are double-buffered: writes land in a shadow copy and are moved to the
//   active copy only at a frame boundary. The enable bit acts immediately.
//
// Ports
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_wr_valid/o_wr_ready, i_wr_addr, i_wr_data
//                       register write (addr 0 = DATA, 1 = CTRL)
//   i_rd_addr/o_rd_data combinational readback of the shadow registers
//   o_seg_out           [7]=dp, [6:0]=g..a, registered, polarity applied
//   o_cc                digit select (bit i = digit i), registered
//   o_frame_tick        one-cycle pulse aligned with digit 0 first appearing
//
// States
//   S_IDLE | display dark, waiting for enable
//   S_SHOW | current digit lit for SCAN_DIV cycles
//   S_GAP  | all digits dark for BLANK_CYC cycles before the next digit
module seg7_scan_ctrl #(
  parameter int SCAN_DIV       = 4000,
  parameter int BLANK_CYC      = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit CC_ACTIVE_LOW  = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wr_valid,
  output logic        o_wr_ready,
  input  logic        i_wr_addr,
  input  logic [31:0] i_wr_data,
  input  logic        i_rd_addr,
  output logic [31:0] o_rd_data,
  output logic [7:0]  o_seg_out,
  output logic [3:0]  o_cc,
  output logic        o_frame_tick
);

  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam bit HAS_GAP = (BLANK_CYC > 0);
  // XOR masks: an active-high "on" pattern XOR the off level gives the pad value.
  localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [3:0] CC_OFF  = CC_ACTIVE_LOW ? 4'hF : 4'h0;

  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP} state_t;

  state_t           r_state;
  logic [1:0]       r_digit;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_sh_data, r_act_data;
  logic [3:0]       r_sh_dp, r_sh_blank, r_act_dp, r_act_blank;
  logic             r_sh_en;
  logic             r_dirty;
  logic             r_wr_ready;
  logic [7:0]       r_seg;
  logic [3:0]       r_cc;
  logic             r_tick;

  logic       w_wr_acc;
  logic       w_show_end, w_gap_end, w_adv, w_load, w_lit;
  logic [3:0] w_nibble;
  logic [6:0] w_dec;
  logic [7:0] w_seg_hi;
  logic [3:0] w_cc_hi;
  logic       w_tick;
  logic       w_unused;

  assign w_wr_acc = i_wr_valid & r_wr_ready;
  assign w_unused = ^{i_wr_data[31:16], i_wr_data[3:1]};

  always_comb begin
    w_show_end = (r_state == S_SHOW) && (r_cnt == SHOW_LAST);
    w_gap_end  = (r_state == S_GAP) && (r_cnt == GAP_LAST);
    w_adv      = (w_show_end && !HAS_GAP) || w_gap_end;
    // Shadow -> active copy: on leaving IDLE, or when wrapping 3 -> 0 with pending writes.
    w_load     = r_sh_en && ((r_state == S_IDLE) || (w_adv && (r_digit == 2'd3) && r_dirty));
  end

  assign w_nibble = r_act_data[{r_digit, 2'b00} +: 4];

  always_comb begin
    w_dec = 7'h00;
    case (w_nibble)
      4'h0: w_dec = 7'h3F;
      4'h1: w_dec = 7'h06;
      4'h2: w_dec = 7'h5B;
      4'h3: w_dec = 7'h4F;
      4'h4: w_dec = 7'h66;
      4'h5: w_dec = 7'h6D;
      4'h6: w_dec = 7'h7D;
      4'h7: w_dec = 7'h07;
      4'h8: w_dec = 7'h7F;
      4'h9: w_dec = 7'h6F;
      4'hA: w_dec = 7'h77;
      4'hB: w_dec = 7'h7C;
      4'hC: w_dec = 7'h39;
      4'hD: w_dec = 7'h5E;
      4'hE: w_dec = 7'h79;
      4'hF: w_dec = 7'h71;
      default: w_dec = 7'h00;
    endcase
  end

  // Gating with r_sh_en darkens the pads on the same edge the FSM drops to IDLE.
  always_comb begin
    w_lit    = r_sh_en && (r_state == S_SHOW);
    w_cc_hi  = w_lit ? (4'b0001 << r_digit) : 4'b0000;
    w_seg_hi = (w_lit && !r_act_blank[r_digit]) ? {r_act_dp[r_digit], w_dec} : 8'h00;
    w_tick   = w_lit && (r_digit == 2'd0) && (r_cnt == '0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_digit     <= 2'd0;
      r_cnt       <= '0;
      r_sh_data   <= 16'h0000;
      r_sh_dp     <= 4'h0;
      r_sh_blank  <= 4'h0;
      r_sh_en     <= 1'b0;
      r_act_data  <= 16'h0000;
      r_act_dp    <= 4'h0;
      r_act_blank <= 4'h0;
      r_dirty     <= 1'b0;
      r_wr_ready  <= 1'b0;
      r_seg       <= SEG_OFF;
      r_cc        <= CC_OFF;
      r_tick      <= 1'b0;
    end else begin
      r_wr_ready <= 1'b1;
      r_seg      <= w_seg_hi ^ SEG_OFF;
      r_cc       <= w_cc_hi ^ CC_OFF;
      r_tick     <= w_tick;

      if (w_wr_acc) begin
        if (!i_wr_addr) begin
          r_sh_data <= i_wr_data[15:0];
        end else begin
          r_sh_en    <= i_wr_data[0];
          r_sh_dp    <= i_wr_data[7:4];
          r_sh_blank <= i_wr_data[11:8];
        end
      end

      // A write coinciding with a transfer keeps dirty set: the transfer took the old shadow.
      if (w_load) begin
        r_act_data  <= r_sh_data;
        r_act_dp    <= r_sh_dp;
        r_act_blank <= r_sh_blank;
        r_dirty     <= w_wr_acc;
      end else if (w_wr_acc) begin
        r_dirty <= 1'b1;
      end

      if (!r_sh_en) begin
        r_state <= S_IDLE;
        r_digit <= 2'd0;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_SHOW;
            r_digit <= 2'd0;
            r_cnt   <= '0;
          end
          S_SHOW: begin
            if (w_show_end) begin
              r_cnt <= '0;
              if (HAS_GAP) r_state <= S_GAP;
              else         r_digit <= r_digit + 2'd1;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          S_GAP: begin
            if (w_gap_end) begin
              r_cnt   <= '0;
              r_state <= S_SHOW;
              r_digit <= r_digit + 2'd1;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_digit <= 2'd0;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign o_wr_ready   = r_wr_ready;
  assign o_rd_data    = i_rd_addr ? {20'b0, r_sh_blank, r_sh_dp, 3'b000, r_sh_en}
                                  : {16'b0, r_sh_data};
  assign o_seg_out    = r_seg;
  assign o_cc         = r_cc;
  assign o_frame_tick = r_tick;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
`timescale 1ns/1ps
module tb_seg7_scan_ctrl;
  localparam int SCAN  = 8;
  localparam int BLK_A = 2;
  localparam int BLK_B = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_addr = 1'b0;
  logic [31:0] wr_data = 32'h0;
  logic        rd_addr = 1'b0;
  logic        wr_ready_a, wr_ready_b;
  logic [31:0] rd_data_a, rd_data_b;
  logic [7:0]  seg_a, seg_b;
  logic [3:0]  cc_a, cc_b;
  logic        tick_a, tick_b;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.SCAN_DIV(SCAN), .BLANK_CYC(BLK_A), .SEG_ACTIVE_LOW(1'b1), .CC_ACTIVE_LOW(1'b1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready_a),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_rd_addr(rd_addr), .o_rd_data(rd_data_a),
    .o_seg_out(seg_a), .o_cc(cc_a), .o_frame_tick(tick_a));

  seg7_scan_ctrl #(.SCAN_DIV(SCAN), .BLANK_CYC(BLK_B), .SEG_ACTIVE_LOW(1'b1), .CC_ACTIVE_LOW(1'b1)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready_b),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_rd_addr(rd_addr), .o_rd_data(rd_data_b),
    .o_seg_out(seg_b), .o_cc(cc_b), .o_frame_tick(tick_b));

  typedef struct packed {
    logic [3:0]  cc_a;
    logic [7:0]  seg_a;
    logic        tick_a;
    logic [3:0]  cc_b;
    logic [7:0]  seg_b;
    logic        tick_b;
    logic        ready;
    logic [31:0] rd;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  // Reference model: frame position arithmetic from the display rules.
  logic [6:0]  dec_tab [16];
  logic [15:0] m_sh_data;
  logic [3:0]  m_dp, m_blank;
  logic        m_en, m_ready;
  int          m_run;
  logic [15:0] m_act_data [2];
  logic [3:0]  m_act_dp [2];
  logic [3:0]  m_act_blank [2];
  logic [3:0]  m_cc [2];
  logic [7:0]  m_seg [2];
  logic        m_tick [2];
  logic        p_rst_n = 1'b0;
  logic        p_valid = 1'b0;
  logic        p_addr = 1'b0;
  logic [31:0] p_data = 32'h0;

  function automatic int slot_len(input int k);
    return SCAN + ((k == 0) ? BLK_A : BLK_B);
  endfunction

  task automatic model_reset();
    m_sh_data = 16'h0; m_dp = 4'h0; m_blank = 4'h0; m_en = 1'b0; m_ready = 1'b0; m_run = 0;
    for (int k = 0; k < 2; k++) begin
      m_act_data[k] = 16'h0; m_act_dp[k] = 4'h0; m_act_blank[k] = 4'h0;
      m_cc[k] = 4'hF; m_seg[k] = 8'hFF; m_tick[k] = 1'b0;
    end
  endtask

  // Advance the model across one rising edge, using the inputs held before it.
  task automatic model_edge();
    int sl, per, pos, d;
    if (!p_rst_n) begin
      model_reset();
      return;
    end
    m_run = m_run + 1;
    for (int k = 0; k < 2; k++) begin
      sl  = slot_len(k);
      per = 4 * sl;
      m_cc[k] = 4'hF; m_seg[k] = 8'hFF; m_tick[k] = 1'b0;
      if (m_en && m_run >= 2) begin
        pos = (m_run - 2) % per;
        d   = pos / sl;
        if ((pos % sl) < SCAN) begin
          m_cc[k] = ~(4'b0001 << d);
          if (!m_act_blank[k][d])
            m_seg[k] = ~{m_act_dp[k][d], dec_tab[m_act_data[k][4*d +: 4]]};
        end
        m_tick[k] = (pos == 0);
      end
      // A frame begins on this edge: it shows the shadow as it stood before the edge.
      if (m_en && ((m_run - 1) % per) == 0) begin
        m_act_data[k]  = m_sh_data;
        m_act_dp[k]    = m_dp;
        m_act_blank[k] = m_blank;
      end
    end
    if (p_valid && m_ready) begin
      if (!p_addr) m_sh_data = p_data[15:0];
      else begin
        if (!m_en && p_data[0]) m_run = 0;
        m_en = p_data[0]; m_dp = p_data[7:4]; m_blank = p_data[11:8];
      end
    end
    m_ready = 1'b1;
  endtask

  function automatic exp_t make_exp();
    exp_t e;
    e.cc_a = m_cc[0]; e.seg_a = m_seg[0]; e.tick_a = m_tick[0];
    e.cc_b = m_cc[1]; e.seg_b = m_seg[1]; e.tick_b = m_tick[1];
    e.ready = m_ready;
    e.rd = rd_addr ? {20'b0, m_blank, m_dp, 3'b000, m_en} : {16'b0, m_sh_data};
    return e;
  endfunction

  task automatic step(input bit rst_assert, input bit v, input bit a, input logic [31:0] d, input bit ra);
    @(posedge clk);
    #1;
    model_edge();
    rst_n = !rst_assert; wr_valid = v; wr_addr = a; wr_data = d; rd_addr = ra;
    if (rst_assert) model_reset();
    p_rst_n = !rst_assert; p_valid = v; p_addr = a; p_data = d;
    exp_q.push_back(make_exp());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, $urandom, 1'($urandom_range(0, 1)));
  endtask

  task automatic wr(input bit a, input logic [31:0] d);
    step(1'b0, 1'b1, a, d, a);
  endtask

  task automatic timeout(input string name);
    n_cmp++; n_fail++;
    $display("FAIL %s: wait bound expired at %0t (actual: not reached, required: reached)", name, $time);
  endtask

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
    end
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cc_a", 32'(cc_a), 32'(e.cc_a));
        chk("seg_a", 32'(seg_a), 32'(e.seg_a));
        chk("tick_a", 32'(tick_a), 32'(e.tick_a));
        chk("cc_b", 32'(cc_b), 32'(e.cc_b));
        chk("seg_b", 32'(seg_b), 32'(e.seg_b));
        chk("tick_b", 32'(tick_b), 32'(e.tick_b));
        chk("wr_ready_a", 32'(wr_ready_a), 32'(e.ready));
        chk("wr_ready_b", 32'(wr_ready_b), 32'(e.ready));
        chk("rd_data_a", rd_data_a, e.rd);
        chk("rd_data_b", rd_data_b, e.rd);
      end
    end
  end

  initial begin : driver
    bit hit;
    int r;
    logic [31:0] d;
    dec_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    model_reset();

    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'hDEAD, 1'b0);   // not accepted: wr_ready still low
    idle(2);

    wr(1'b0, 32'h0000_1234);
    wr(1'b1, 32'h0000_0001);
    idle(90);

    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (m_cc[0] == 4'hD) hit = 1;
      else idle(1);
    end
    if (!hit) timeout("wait_digit1");
    wr(1'b0, 32'h0000_ABCD);
    idle(100);

    wr(1'b1, 32'h0000_00A1);
    idle(100);
    wr(1'b1, 32'h0000_0401);
    idle(100);

    wr(1'b0, 32'h0000_1234);
    wr(1'b1, 32'h0000_0001);
    idle(50);
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      if (m_en && m_run > 0 && (m_run % (4 * slot_len(0))) == (4 * slot_len(0) - 1)) hit = 1;
      else idle(1);
    end
    if (!hit) timeout("wait_wrap");
    wr(1'b0, 32'h0000_FFFF);
    idle(120);

    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (m_cc[0] != 4'hF) hit = 1;
      else idle(1);
    end
    if (!hit) timeout("wait_show");
    wr(1'b1, 32'h0000_0000);
    idle(10);
    wr(1'b1, 32'h0000_0001);
    idle(100);

    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (m_cc[0] == 4'hB) hit = 1;
      else idle(1);
    end
    if (!hit) timeout("wait_digit2");
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    idle(5);

    wr(1'b0, 32'h0000_5A3C);
    wr(1'b1, 32'h0000_0001);
    for (int i = 0; i < 2500; i++) begin
      r = $urandom_range(0, 199);
      d = $urandom;
      if (r < 2) begin
        step(1'b1, 1'b0, 1'b0, d, 1'($urandom_range(0, 1)));
        step(1'b0, 1'b0, 1'b0, d, 1'($urandom_range(0, 1)));
        wr(1'b1, 32'h0000_0001);
      end else if (r < 20) begin
        step(1'b0, 1'b1, 1'b0, d, 1'($urandom_range(0, 1)));
      end else if (r < 28) begin
        d[0] = ($urandom_range(0, 99) < 80);
        step(1'b0, 1'b1, 1'b1, d, 1'($urandom_range(0, 1)));
      end else if (r < 34 && !m_en) begin
        step(1'b0, 1'b1, 1'b1, d | 32'h1, 1'($urandom_range(0, 1)));
      end else begin
        step(1'b0, 1'b0, 1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)));
      end
    end

    idle(3);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
